// File: rtl/bist_lfsr_misr_ctrl_if.sv
// Signal bundle between the BIST controller and its environment.
// The environment drives start, golden and CUT responses; the controller drives the rest.
interface bist_lfsr_misr_ctrl_if #(
    parameter int unsigned MISR_W = 8
);
    logic              start_i;
    logic [MISR_W-1:0] golden_sig_i;
    logic [5:0]        pattern_o;
    logic [1:0]        resp_i;
    logic              busy_o;
    logic              done_o;
    logic              pass_o;
    logic [MISR_W-1:0] signature_o;
    logic [5:0]        pat_count_o;

    modport master (
        output start_i, golden_sig_i, resp_i,
        input  pattern_o, busy_o, done_o, pass_o, signature_o, pat_count_o
    );

    modport slave (
        input  start_i, golden_sig_i, resp_i,
        output pattern_o, busy_o, done_o, pass_o, signature_o, pat_count_o
    );
endinterface

// File: rtl/bist_lfsr_misr_ctrl.sv
// BIST run sequencer: LFSR pattern source, MISR response compactor and
// IDLE/RUN/DONE control with a golden-signature compare at the end of each run.
module bist_lfsr_misr_ctrl #(
    parameter int unsigned       NUM_PATTERNS = 63,
    parameter logic [5:0]        SEED         = 6'h01,
    parameter logic [5:0]        LFSR_TAPS    = 6'b110000,
    parameter int unsigned       MISR_W       = 8,
    parameter logic [MISR_W-1:0] MISR_TAPS    = MISR_W'(8'hB8)
) (
    input logic                    clk,
    input logic                    rst,
    bist_lfsr_misr_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [5:0] LastCount = 6'(NUM_PATTERNS - 1);

    state_e            r_state, w_state;
    logic [5:0]        r_pattern, w_pattern;
    logic [MISR_W-1:0] r_misr, w_misr;
    logic [5:0]        r_count, w_count;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              r_pass, w_pass;

    logic [MISR_W-1:0] w_misr_step;
    logic [5:0]        w_lfsr_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_pattern <= '0;
            r_misr    <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_pattern <= w_pattern;
            r_misr    <= w_misr;
            r_count   <= w_count;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_pass    <= w_pass;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_pattern = r_pattern;
        w_misr    = r_misr;
        w_count   = r_count;
        w_busy    = r_busy;
        w_done    = r_done;
        w_pass    = r_pass;

        // Response bits enter the low end of the shifted signature.
        w_misr_step = {r_misr[MISR_W-2:0], ^(r_misr & MISR_TAPS)} ^ MISR_W'(bus.resp_i);
        w_lfsr_step = {r_pattern[4:0], ^(r_pattern & LFSR_TAPS)};

        unique case (r_state)
            StIdle, StDone: begin
                if (bus.start_i) begin
                    w_state   = StRun;
                    w_pattern = SEED;
                    w_misr    = '0;
                    w_count   = '0;
                    w_busy    = 1'b1;
                    w_done    = 1'b0;
                    w_pass    = 1'b0;
                end
            end
            StRun: begin
                w_misr  = w_misr_step;
                w_count = r_count + 6'd1;
                if (r_count == LastCount) begin
                    w_state   = StDone;
                    w_pattern = '0;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                    w_pass    = (w_misr_step == bus.golden_sig_i);
                end else begin
                    w_pattern = w_lfsr_step;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    assign bus.pattern_o   = r_pattern;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.pass_o      = r_pass;
    assign bus.signature_o = r_misr;
    assign bus.pat_count_o = r_count;

endmodule

// File: tb/tb_bist_lfsr_misr_ctrl.sv
// Self-checking bench: main instance (63 patterns) against a software signature model,
// plus a 3-pattern instance for hand-computed MISR arithmetic.
module tb_bist_lfsr_misr_ctrl;

    localparam int NP = 63;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bist_lfsr_misr_ctrl_if #(.MISR_W(8)) bus ();
    bist_lfsr_misr_ctrl_if #(.MISR_W(8)) bus3 ();

    bist_lfsr_misr_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bist_lfsr_misr_ctrl #(.NUM_PATTERNS(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    logic       cut_mode;
    logic [1:0] r_resp;
    logic [5:0] seq [NP];
    logic [5:0] lfsr_tab [7] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21, 6'h03};
    logic [7:0] sig3_tab [3] = '{8'h01, 8'h03, 8'h07};
    int n_checks = 0;
    int n_pass   = 0;

    // Small 6-in/2-out benchmark: s1 = ab | (c^d), s2 = (d|e) ^ (f&a).
    function automatic logic [1:0] cut(input logic [5:0] p);
        logic a, b, c, d, e, f;
        {a, b, c, d, e, f} = p;
        return {(a & b) | (c ^ d), (d | e) ^ (f & a)};
    endfunction

    assign bus.resp_i  = cut_mode ? cut(bus.pattern_o) : r_resp;
    assign bus3.resp_i = 2'b01;

    function automatic logic [7:0] misr_next(input logic [7:0] s, input logic [1:0] r);
        int unsigned fb;
        fb = $countones(s & 8'hB8) % 2;
        return 8'(((int'(s) * 2) % 256 + fb)) ^ {6'd0, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // mode 0: zero response, 1: random response, 2: closed loop through the CUT.
    task automatic run_main(input int mode);
        logic [7:0] m;
        logic [1:0] r;
        bit         good;
        m = 8'h00;
        good = 1'b1;
        cut_mode = (mode == 2);
        if (mode == 0) bus.golden_sig_i = 8'h00;
        if (mode == 2) begin
            logic [7:0] g;
            g = 8'h00;
            for (int i = 0; i < NP; i++) g = misr_next(g, cut(seq[i]));
            bus.golden_sig_i = g;
        end
        r_resp = 2'b00;
        @(negedge clk);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        for (int n = 0; n < NP; n++) begin
            check($sformatf("m%0d pattern[%0d]", mode, n), 32'(bus.pattern_o), 32'(seq[n]));
            check($sformatf("m%0d sig[%0d]", mode, n), 32'(bus.signature_o), 32'(m));
            check($sformatf("m%0d count[%0d]", mode, n), 32'(bus.pat_count_o), n);
            check($sformatf("m%0d busy[%0d]", mode, n), 32'(bus.busy_o), 1);
            check($sformatf("m%0d done[%0d]", mode, n), 32'(bus.done_o), 0);
            if (mode == 0 && n < 7)
                check($sformatf("lfsr_order[%0d]", n), 32'(bus.pattern_o), 32'(lfsr_tab[n]));
            if (mode == 1) begin
                r = 2'($urandom);
                r_resp = r;
                bus.start_i = (n == 20);
            end else if (mode == 2) begin
                r = cut(seq[n]);
            end else begin
                r = 2'b00;
            end
            m = misr_next(m, r);
            if (mode == 1 && n == NP - 1) begin
                good = 1'($urandom_range(0, 1));
                bus.golden_sig_i = good ? m : (m ^ 8'h5A);
            end
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        check($sformatf("m%0d end_done", mode), 32'(bus.done_o), 1);
        check($sformatf("m%0d end_busy", mode), 32'(bus.busy_o), 0);
        check($sformatf("m%0d end_pattern", mode), 32'(bus.pattern_o), 0);
        check($sformatf("m%0d end_count", mode), 32'(bus.pat_count_o), NP);
        check($sformatf("m%0d end_sig", mode), 32'(bus.signature_o), 32'(m));
        check($sformatf("m%0d end_pass", mode), 32'(bus.pass_o), 32'(good));
    endtask

    task automatic run_three(input logic [7:0] golden, input bit exp_pass);
        bus3.golden_sig_i = golden;
        @(negedge clk);
        bus3.start_i = 1'b1;
        @(negedge clk);
        bus3.start_i = 1'b0;
        check("misr3_sig_start", 32'(bus3.signature_o), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("misr3_sig[%0d]", i), 32'(bus3.signature_o), 32'(sig3_tab[i]));
        end
        check("misr3_done", 32'(bus3.done_o), 1);
        check("misr3_count", 32'(bus3.pat_count_o), 3);
        check("misr3_pass", 32'(bus3.pass_o), 32'(exp_pass));
    endtask

    initial begin
        logic [5:0] p;
        p = 6'h01;
        for (int i = 0; i < NP; i++) begin
            seq[i] = p;
            p = 6'(((int'(p) * 2) % 64) + ($countones(p & 6'b110000) % 2));
        end

        rst = 1'b1;
        cut_mode = 1'b0;
        r_resp = 2'b00;
        bus.start_i = 1'b0;
        bus.golden_sig_i = 8'h00;
        bus3.start_i = 1'b0;
        bus3.golden_sig_i = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_pattern", 32'(bus.pattern_o), 0);
        check("rst_sig", 32'(bus.signature_o), 0);
        check("rst_count", 32'(bus.pat_count_o), 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_done", 32'(bus.done_o), 0);
        check("rst_pass", 32'(bus.pass_o), 0);
        rst = 1'b0;

        run_main(0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("hold_done[%0d]", i), 32'(bus.done_o), 1);
            check($sformatf("hold_pass[%0d]", i), 32'(bus.pass_o), 1);
            check($sformatf("hold_sig[%0d]", i), 32'(bus.signature_o), 0);
            check($sformatf("hold_count[%0d]", i), 32'(bus.pat_count_o), NP);
        end

        run_three(8'h07, 1'b1);
        run_three(8'h06, 1'b0);

        run_main(1);
        run_main(1);

        // Abort a run part-way through with an asynchronous reset.
        @(negedge clk);
        bus.start_i = 1'b1;
        r_resp = 2'b11;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_count", 32'(bus.pat_count_o), 10);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy_o), 0);
        check("abort_pattern", 32'(bus.pattern_o), 0);
        check("abort_sig", 32'(bus.signature_o), 0);
        check("abort_done", 32'(bus.done_o), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("idle_busy[%0d]", i), 32'(bus.busy_o), 0);
            check($sformatf("idle_done[%0d]", i), 32'(bus.done_o), 0);
            check($sformatf("idle_count[%0d]", i), 32'(bus.pat_count_o), 0);
        end

        run_main(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bist_lfsr_misr_ctrl.md
Name: bist_lfsr_misr_ctrl

Overview:
- Built-in self-test wrapper stage for the small combinational benchmark circuits (6 inputs a..f, 2 outputs s1/s2).
- Upstream side: a maximal-length LFSR drives test patterns into the circuit-under-test (CUT).
- Downstream side: a MISR compacts the CUT responses into a signature.
- An FSM sequences one run per start request, then compares the signature against a golden value.

Parameters:
- NUM_PATTERNS, 63, patterns applied per run; legal range 1..63.
- SEED, 6'h01, LFSR load value; must be nonzero.
- LFSR_TAPS, 6'b110000, LFSR feedback mask (x^6+x^5+1).
- MISR_W, 8, signature width; must be at least 2.
- MISR_TAPS, 8'hB8, MISR feedback mask; width MISR_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  run request, sampled in IDLE/DONE.
- golden_sig_i  in  MISR_W  expected signature; sampled at the final RUN edge.
- pattern_o  out  6  CUT stimulus; [5]=a, [4]=b, [3]=c, [2]=d, [1]=e, [0]=f.
- resp_i  in  2  CUT response; [1]=s1, [0]=s2; combinational from pattern_o.
- busy_o  out  1  high while in RUN.
- done_o  out  1  high in DONE.
- pass_o  out  1  signature == golden; valid while done_o=1.
- signature_o  out  MISR_W  current MISR register.
- pat_count_o  out  6  patterns absorbed in the current run.

Behaviour:
- Reset (async, immediate): state=IDLE; pattern_o=0, MISR=0, count=0, busy_o=0, done_o=0, pass_o=0. Reset mid-RUN aborts the run with no partial done.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE or DONE, start_i=1 at an edge:
  - go to RUN;
  - pattern_o<=SEED, MISR<=0, count<=0;
  - busy_o<=1, done_o<=0, pass_o<=0.
- IDLE or DONE, start_i=0: hold all state. DONE keeps done_o, pass_o and the signature stable.
- RUN, every edge:
  - MISR <= {MISR[MISR_W-2:0], fbm} XOR zero-extended resp_i, where fbm = XOR-reduce(MISR & MISR_TAPS). resp_i enters the low 2 bits.
  - pattern_o <= {pattern_o[4:0], fb}, where fb = XOR-reduce(pattern_o & LFSR_TAPS).
  - count <= count+1.
- RUN, edge with count==NUM_PATTERNS-1 (the final absorb):
  - go to DONE; busy_o<=0, done_o<=1;
  - pass_o <= (next MISR value == golden_sig_i);
  - pattern_o<=0 to quiet the CUT;
  - count becomes NUM_PATTERNS.
- start_i is ignored in RUN.
- Timing: start sampled at edge k; pattern n (n=0..NUM_PATTERNS-1) is driven between edges k+n and k+n+1, and its response is absorbed at edge k+n+1. done_o rises at edge k+NUM_PATTERNS.
- Response path: the CUT must settle within one cycle; resp_i is sampled once per pattern.
- LFSR wrap: period 63. With NUM_PATTERNS ≤ 63 no pattern repeats within a run, and all-zero is never generated.
- Widths: pat_count_o is 6 bits and never exceeds 63. MISR arithmetic is pure XOR, so no carries.

Test Plan:
- LFSR order: reset, start pulse, resp_i=0 -> pattern_o sequence 01,02,04,08,10,21,03 (hex) on consecutive cycles; busy_o=1 throughout.
- Zero response: resp_i tied 0, golden=0x00, NUM_PATTERNS=63 -> done_o rises 63 cycles after start, signature_o=0x00, pass_o=1, pat_count_o=63, pattern_o=0.
- MISR arithmetic: NUM_PATTERNS=3, resp_i held 2'b01 -> signature after edges 0x01, 0x03, 0x07; golden=0x07 gives pass_o=1; golden=0x06 gives pass_o=0 with done_o=1.
- Reset mid-run: assert rst at pat_count_o=10 -> same cycle busy_o=0, pattern_o=0, signature_o=0, done_o=0; after release the block stays IDLE until start.
- Handshake: pulse start_i during RUN -> no restart, count continues. In DONE, start_i=1 -> RUN restarts with pattern_o=SEED, done_o=0, signature cleared. Without start, DONE outputs hold for ≥20 cycles.
- Closed loop with the 6-in/2-out benchmark circuit connected: signature_o equals the bench's software model signature over 63 patterns, and pass_o=1 when that model value is fed as golden.
